// File: rtl/usb_tx.sv
// usb_tx: USB low/full speed transmitter.
// Takes bytes from the SIE over a valid/ready handshake. Sends SYNC, then the
// bytes LSB first with bit stuffing and NRZI coding, then EOP (SE0, SE0, J).
// One line symbol is produced per clk_en strobe, so clk_en alone sets the bit rate.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset (not gated by clk_en)
//   clk_en  in   bit-rate strobe, one line symbol per asserted cycle
//   data    in   byte from SIE, sampled only in a load slot
//   valid   in   SIE has a byte to send
//   ready   out  one-clk pulse, byte on data consumed
//   txd     out  line state (J, K, SE0)
//   oe      out  transceiver output enable, SYNC through EOP J
//   active  out  packet in progress, identical to oe

package usb_tx_pkg;
   typedef enum logic [1:0] {
      DSe0 = 2'b00,
      DK   = 2'b01,
      DJ   = 2'b10
   } d_port_t;
endpackage

module usb_tx
   import usb_tx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_en,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output d_port_t    txd,
   output logic       oe,
   output logic       active
);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StData,
      StEop1,
      StEopJ
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] ones_q, ones_d;
   logic       level_q, level_d;       // current NRZI level, 1 = J
   d_port_t    txd_q, txd_d;
   logic       oe_q, oe_d;
   logic       ready_q;
   logic       idle_hold_q, idle_hold_d;
   logic       load;
   logic       tx_en;                  // a bit goes through NRZI this slot
   logic       tx_bit;

   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      ones_d      = ones_q;
      level_d     = level_q;
      txd_d       = txd_q;
      oe_d        = oe_q;
      idle_hold_d = idle_hold_q;
      load        = 1'b0;
      tx_en       = 1'b0;
      tx_bit      = 1'b0;

      unique case (state_q)
         StIdle: begin
            txd_d     = DJ;
            oe_d      = 1'b0;
            level_d   = 1'b1;
            ones_d    = 3'd0;
            bit_idx_d = 3'd0;
            // The first idle slot after EOP is always spent on J.
            if (idle_hold_q) begin
               idle_hold_d = 1'b0;
            end else if (valid) begin
               state_d = StSync;
            end
         end
         StSync: begin
            oe_d      = 1'b1;
            tx_en     = 1'b1;
            tx_bit    = (bit_idx_q == 3'd7);
            bit_idx_d = bit_idx_q + 3'd1;  // wraps to 0, ready for the first load slot
            if (bit_idx_q == 3'd7) begin
               state_d = StData;
            end
         end
         StData: begin
            oe_d = 1'b1;
            if (ones_q == 3'd6) begin
               // Stuff slot: a forced zero; shift register and bit index hold.
               tx_en  = 1'b1;
               tx_bit = 1'b0;
            end else if (bit_idx_q == 3'd0) begin
               if (valid) begin
                  load      = 1'b1;
                  tx_en     = 1'b1;
                  tx_bit    = data[0];
                  shift_d   = {1'b0, data[7:1]};
                  bit_idx_d = 3'd1;
               end else begin
                  // No byte offered: this slot is the first SE0 of EOP.
                  txd_d   = DSe0;
                  state_d = StEop1;
               end
            end else begin
               tx_en     = 1'b1;
               tx_bit    = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         StEop1: begin
            oe_d    = 1'b1;
            txd_d   = DSe0;
            state_d = StEopJ;
         end
         StEopJ: begin
            oe_d        = 1'b1;
            txd_d       = DJ;
            level_d     = 1'b1;
            idle_hold_d = 1'b1;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // NRZI: a zero toggles the line, a one holds it.
      if (tx_en) begin
         level_d = tx_bit ? level_q : ~level_q;
         ones_d  = tx_bit ? (ones_q + 3'd1) : 3'd0;
         txd_d   = level_d ? DJ : DK;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'd0;
         ones_q      <= 3'd0;
         level_q     <= 1'b1;
         txd_q       <= DJ;
         oe_q        <= 1'b0;
         ready_q     <= 1'b0;
         idle_hold_q <= 1'b0;
      end else begin
         // Updated every clk so the pulse is exactly one clk wide.
         ready_q <= load & clk_en;
         if (clk_en) begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            ones_q      <= ones_d;
            level_q     <= level_d;
            txd_q       <= txd_d;
            oe_q        <= oe_d;
            idle_hold_q <= idle_hold_d;
         end
      end
   end

   assign ready  = ready_q;
   assign txd    = txd_q;
   assign oe     = oe_q;
   assign active = oe_q;

endmodule

// File: tb/tb_usb_tx.sv
module tb_usb_tx;
   import usb_tx_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       clk_en;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   d_port_t    txd;
   logic       oe;
   logic       active;

   always #5 clk = ~clk;

   usb_tx dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .data   (data),
      .valid  (valid),
      .ready  (ready),
      .txd    (txd),
      .oe     (oe),
      .active (active)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int viol     = 0;

   function automatic void check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic void check_str(input string name, input string act, input string exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %s, expected %s", name, act, exp);
   endfunction

   // clk_en strobe: one of every en_period clocks
   int en_period = 1;
   int en_cnt    = 0;
   always @(negedge clk) begin
      en_cnt = (en_cnt + 1) % en_period;
      clk_en = (en_cnt == 0);
   end

   // Slot monitor: one record per clk_en edge while capturing
   typedef struct {
      d_port_t txd;
      logic    oe;
      logic    rdy;
   } slot_t;

   slot_t   slot_log[$];
   logic    capture = 1'b0;
   logic    en_s, rst_s, prev_oe, prev_rdy;
   d_port_t prev_txd;
   slot_t   s_rec;

   always @(posedge clk) begin
      en_s  = clk_en;
      rst_s = reset;
      #1;
      if (!rst_s) begin
         if (!en_s && (txd !== prev_txd || oe !== prev_oe)) viol++;
         if (ready === 1'b1 && (!en_s || prev_rdy)) viol++;
         if (en_s && capture) begin
            s_rec.txd = txd;
            s_rec.oe  = oe;
            s_rec.rdy = ready;
            slot_log.push_back(s_rec);
         end
      end
      if (active !== oe) viol++;
      prev_txd = txd;
      prev_oe  = oe;
      prev_rdy = ready;
   end

   function automatic string sym_char(input d_port_t d);
      case (d)
         DJ:      return "J";
         DK:      return "K";
         DSe0:    return "0";
         default: return "?";
      endcase
   endfunction

   function automatic string lvl_char(input bit l);
      return l ? "J" : "K";
   endfunction

   // Reference: raw bit list -> insert a 0 after every six 1s -> NRZI from J -> EOP
   function automatic void model(input logic [7:0] b[$], output string sym, output int rp[$]);
      bit bits[$];
      int starts[$];
      int ones;
      bit lvl;
      int si;
      ones = 0;
      lvl  = 1'b1;
      si   = 0;
      sym  = "";
      rp.delete();
      for (int i = 0; i < 7; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
      for (int k = 0; k < b.size(); k++) begin
         starts.push_back(bits.size());
         for (int j = 0; j < 8; j++) bits.push_back(b[k][j]);
      end
      for (int i = 0; i < bits.size(); i++) begin
         if (si < starts.size() && starts[si] == i) begin
            rp.push_back(sym.len());
            si++;
         end
         if (!bits[i]) lvl = !lvl;
         sym  = {sym, lvl_char(lvl)};
         ones = bits[i] ? ones + 1 : 0;
         if (ones == 6) begin
            lvl  = !lvl;
            sym  = {sym, lvl_char(lvl)};
            ones = 0;
         end
      end
      sym = {sym, "00J"};
   endfunction

   task automatic wait_for(input int kind, input d_port_t v, input string tag);
      int cyc;
      bit hit;
      cyc = 0;
      hit = 1'b0;
      while (!hit && cyc < 5000) begin
         @(posedge clk);
         #2;
         cyc++;
         case (kind)
            0:       hit = (ready === 1'b1);
            1:       hit = (oe === 1'b0);
            2:       hit = (txd === v);
            default: hit = 1'b1;
         endcase
      end
      if (!hit) begin
         n_checks++;
         $display("FAIL %s: timed out after %0d clks waiting for event", tag, cyc);
      end
   endtask

   // Drive one packet of b (may be empty) and capture its slots
   task automatic send(input logic [7:0] b[$], input string tag);
      int  idx;
      int  cyc;
      bit  seen_oe;
      idx     = 0;
      cyc     = 0;
      seen_oe = 1'b0;
      slot_log.delete();
      capture = 1'b1;
      @(negedge clk);
      data  = (b.size() > 0) ? b[0] : 8'h00;
      valid = 1'b1;
      while (cyc < 5000) begin
         @(posedge clk);
         #2;
         cyc++;
         if (oe) seen_oe = 1'b1;
         if (b.size() == 0 && oe) valid = 1'b0;
         if (ready) begin
            idx++;
            if (idx < b.size()) data = b[idx];
            else valid = 1'b0;
         end
         if (seen_oe && !oe) break;
      end
      valid = 1'b0;
      check_int({tag, " packet completes"}, int'(seen_oe && !oe), 1);
      repeat (en_period + 2) @(posedge clk);
      #2;
      capture = 1'b0;
   endtask

   task automatic check_packet(input string tag, input string exp_sym, input int exp_rdy[$],
                               input int from, output int next_from);
      int    start;
      int    stop;
      string got;
      int    rd[$];
      start = -1;
      stop  = -1;
      got   = "";
      for (int i = from; i < slot_log.size(); i++) begin
         if (slot_log[i].oe) begin
            start = i;
            break;
         end
      end
      if (start >= 0) begin
         for (int i = start; i < slot_log.size(); i++) begin
            if (!slot_log[i].oe) begin
               stop = i;
               break;
            end
            got = {got, sym_char(slot_log[i].txd)};
            if (slot_log[i].rdy) rd.push_back(i - start);
         end
      end
      check_str({tag, " symbols"}, got, exp_sym);
      check_int({tag, " ready count"}, rd.size(), exp_rdy.size());
      for (int i = 0; i < rd.size() && i < exp_rdy.size(); i++)
         check_int($sformatf("%s ready slot %0d", tag, i), rd[i], exp_rdy[i]);
      check_int({tag, " idle J after EOP"},
                int'(stop >= 0 && slot_log[stop].txd == DJ), 1);
      next_from = (stop >= 0) ? stop : slot_log.size();
   endtask

   typedef struct {
      int         nb;
      logic [7:0] b [4];
      int         period;
      string      exp;
      int         gap;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                          input int period, input string exp, input int gap);
      vec_t v;
      v.nb     = nb;
      v.b[0]   = b0;
      v.b[1]   = b1;
      v.b[2]   = 8'h00;
      v.b[3]   = 8'h00;
      v.period = period;
      v.exp    = exp;
      v.gap    = gap;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] q[$];
      int         er[$];
      int         nf;
      int         nf2;
      int         gap;
      string      es;
      int         periods[4];

      reset  = 1'b1;
      valid  = 1'b0;
      data   = 8'h00;
      clk_en = 1'b0;
      periods[0] = 1;
      periods[1] = 2;
      periods[2] = 3;
      periods[3] = 16;

      add_vec(1, 8'h00, 8'h00, 1, "KJKJKJKKJKJKJKJK00J", 0);
      add_vec(1, 8'hFF, 8'h00, 1, "KJKJKJKKKKKKKJJJJ00J", 0);
      add_vec(2, 8'h2D, 8'hA5, 1, "KJKJKJKKKJJJKKJKKJJKJJKK00J", 8);
      add_vec(2, 8'hFC, 8'h00, 1, "KJKJKJKKJKKKKKKKJKJKJKJKJ00J", 9);
      add_vec(2, 8'h2D, 8'hA5, 16, "KJKJKJKKKJJJKKJKKJJKJJKK00J", 8);
      add_vec(2, 8'h2D, 8'hA5, 2, "KJKJKJKKKJJJKKJKKJJKJJKK00J", 8);
      add_vec(0, 8'h00, 8'h00, 1, "KJKJKJKK00J", 0);

      repeat (3) @(posedge clk);
      #1;
      check_int("reset txd", int'(txd), int'(DJ));
      check_int("reset oe", int'(oe), 0);
      check_int("reset active", int'(active), 0);
      check_int("reset ready", int'(ready), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);

      // Directed vectors
      foreach (vecs[i]) begin
         en_period = vecs[i].period;
         repeat (2) @(posedge clk);
         q.delete();
         er.delete();
         for (int k = 0; k < vecs[i].nb; k++) begin
            q.push_back(vecs[i].b[k]);
            er.push_back(8 + k * vecs[i].gap);
         end
         send(q, $sformatf("vec%0d", i));
         check_packet($sformatf("vec%0d", i), vecs[i].exp, er, 0, nf);
      end

      // Next packet requested as soon as EOP J is on the line
      en_period = 1;
      repeat (2) @(posedge clk);
      slot_log.delete();
      capture = 1'b1;
      @(negedge clk);
      data  = 8'h00;
      valid = 1'b1;
      wait_for(0, DJ, "gap first ready");
      valid = 1'b0;
      wait_for(2, DSe0, "gap first EOP");
      wait_for(2, DJ, "gap EOP J");
      valid = 1'b1;
      wait_for(0, DJ, "gap second ready");
      valid = 1'b0;
      wait_for(1, DJ, "gap second end");
      repeat (3) @(posedge clk);
      #2;
      capture = 1'b0;
      q.delete();
      q.push_back(8'h00);
      model(q, es, er);
      check_packet("gap pkt1", es, er, 0, nf);
      gap = 0;
      while (nf + gap < slot_log.size() && !slot_log[nf + gap].oe) gap++;
      check_int("gap idle slot between packets", int'(gap >= 1), 1);
      check_packet("gap pkt2", es, er, nf, nf2);

      // Reset in the middle of the second byte
      @(negedge clk);
      data  = 8'h2D;
      valid = 1'b1;
      wait_for(0, DJ, "rst first ready");
      data = 8'hA5;
      wait_for(0, DJ, "rst second ready");
      valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_int("mid reset txd", int'(txd), int'(DJ));
      check_int("mid reset oe", int'(oe), 0);
      check_int("mid reset active", int'(active), 0);
      check_int("mid reset ready", int'(ready), 0);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      q.push_back(8'h00);
      send(q, "after reset");
      model(q, es, er);
      check_packet("after reset", es, er, 0, nf);

      // Random packets against the reference model
      for (int r = 0; r < 16; r++) begin
         int nb;
         en_period = periods[$urandom_range(0, 3)];
         repeat (2) @(posedge clk);
         nb = $urandom_range(0, 4);
         q.delete();
         for (int k = 0; k < nb; k++)
            q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
         send(q, $sformatf("rnd%0d", r));
         model(q, es, er);
         check_packet($sformatf("rnd%0d", r), es, er, 0, nf);
      end

      check_int("output change off-strobe or wide ready", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
